aes128_key_expander: RTL and testbench
======================================

Name: aes128_key_expander

Overview:
- Iterative AES-128 key schedule. Sits directly upstream of the cipher round datapath and supplies its round keys.
- Accepts a 128-bit cipher key on a load pulse and computes round keys 0..10, one per cycle.
- Stores all 11 round keys in an internal register file. The cipher reads any round key by index.

Parameters:
- NUM_ROUNDS, 10, number of expansion rounds. Fixed at 10 for AES-128; other values unsupported.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- key_in  in  128  cipher key; key_in[127:96] = w0
- key_load  in  1  single-cycle request to start expansion of key_in
- busy  out  1  expansion in progress
- key_ready  out  1  all 11 round keys valid
- rd_idx  in  4  round-key read index, 0..10
- rd_key  out  128  round key rd_idx, combinational read
- rd_valid  out  1  the entry addressed by rd_idx is valid
- last_key  out  128  round key 10, registered

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - busy=0, key_ready=0, last_key=0.
  - All store entries = 0; round counter cnt=0; state IDLE.
  - Reset mid-expansion aborts immediately, with the same values.
- States: IDLE, EXPAND, DONE.
- Load accepted (key_load=1 while state is IDLE or DONE):
  - store[0] <= key_in; working key cur <= key_in; cnt <= 1.
  - key_ready <= 0; busy <= 1; state -> EXPAND.
- EXPAND, each cycle:
  - nxt = step(cur, RCON[cnt]); store[cnt] <= nxt; cur <= nxt; cnt <= cnt+1.
  - When cnt==10: last_key <= nxt, busy <= 0, key_ready <= 1, state -> DONE.
- step(w0..w3, rc):
  - t = SubWord(RotWord(w3)) ^ {rc, 24'h0}, with RotWord(w) = {w[23:0], w[31:24]}.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
- RCON[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- Latency: load sampled at edge E0; round k written at edge Ek; key_ready high from E10 onward, i.e. 10 cycles after the load edge.
- key_load while busy: ignored. No queueing; the expansion in flight is unaffected.
- key_load in DONE: restarts expansion; key_ready drops on the next edge.
- rd_valid:
  - = key_ready OR (busy AND rd_idx < cnt) OR (busy AND rd_idx==0).
  - rd_idx > 10: rd_key = 0, rd_valid = 0.
- rd_key always reflects the store contents. Stale entries from a previous key remain readable until overwritten, but rd_valid=0 marks them invalid.

Optional Feature:
- Macro: AES_KEYEXP_SBOX_PIPE_EN.
- Defined:
  - The SubWord output is registered.
  - Each round takes 2 cycles: a SUB phase registers t, an XOR phase writes store[cnt].
  - key_ready rises 20 cycles after the load edge.
  - rd_valid semantics are unchanged; cnt increments only on the XOR phase.
- Undefined: single-cycle rounds as described above, with 10-cycle latency.

Decomposition:
- Package aes_pkg:
  - NUM_ROUNDS = 10.
  - RCON table as a function of round index.
  - 32-bit word and 128-bit block typedefs.
  - State enum.
- Sub-module aes_key_step:
  - Purely combinational single expansion step (cur, rc -> nxt).
  - Instantiates four copies of the existing sbox module.
  - The top level holds the FSM, counter and 11x128 store.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, pulse key_load:
  - key_ready asserts exactly 10 cycles after the load edge.
  - rd_idx=1 -> a0fafe1788542cb123a339392a6c7605.
  - rd_idx=10 and last_key -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key:
  - rd_idx=1 -> 62636363626363636263636362636363.
  - rd_idx=10 -> b4ef5bcb3e92e21123e951cf6f8f188e.
- Second key_load 4 cycles into an expansion of the FIPS key: ignored; final keys equal the FIPS vectors; latency still 10 cycles.
- rst asserted at cycle 5 of an expansion:
  - Next cycle: busy=0, key_ready=0, last_key=0, rd_key(idx 3)=0.
  - A fresh load then completes correctly.
- Reload in DONE with the zero key:
  - key_ready=0 on the next edge.
  - During expansion, rd_idx=7 gives rd_valid=0 until edge E7, then the zero-key round-7 value.
  - rd_idx=11 -> rd_key=0, rd_valid=0.
- With AES_KEYEXP_SBOX_PIPE_EN defined: the FIPS vector gives identical keys; key_ready asserts 20 cycles after the load edge.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types, round constants and FSM encoding for the AES-128 key schedule.
// Optional build macro used downstream: AES_KEYEXP_SBOX_PIPE_EN.
package aes_pkg;

   localparam int NUM_ROUNDS = 10;

   typedef logic [31:0]  word_t;
   typedef logic [127:0] block_t;

   typedef enum logic [1:0] {
      IDLE,
      EXPAND,
      DONE
   } state_t;

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key schedule step: SubWord/RotWord/Rcon on w3, then the
// chained XOR. t_out/t_in are split so the caller may register t.
module aes_key_step
   import aes_pkg::*;
(
   input  logic [127:0] cur,
   input  logic [7:0]   rc,
   output logic [31:0]  t_out,
   input  logic [31:0]  t_in,
   output logic [127:0] nxt
);

   word_t rot;
   word_t sub;
   word_t w0;
   word_t w1;
   word_t w2;
   word_t w3;

   assign rot = {cur[23:0], cur[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sb
      aes_sbox u_sbox (
         .a(rot[8*i +: 8]),
         .s(sub[8*i +: 8])
      );
   end

   assign t_out = sub ^ {rc, 24'h0};

   assign w0  = cur[127:96] ^ t_in;
   assign w1  = cur[95:64]  ^ w0;
   assign w2  = cur[63:32]  ^ w1;
   assign w3  = cur[31:0]   ^ w2;
   assign nxt = {w0, w1, w2, w3};

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box, byte lookup from a packed constant table.
// Purely combinational; shared by the key schedule step.
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] s
);

   localparam logic [2047:0] TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry 0 sits in the top byte, so the bit offset is (255-a)*8.
   logic [10:0] base;
   assign base = {~a, 3'b000};
   assign s    = TBL[base +: 8];

endmodule

// File: rtl/aes128_key_expander.sv
// Iterative AES-128 key expander with an 11-entry round-key store.
// AES_KEYEXP_SBOX_PIPE_EN registers SubWord, making each round 2 cycles.
module aes128_key_expander
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] key_in,
   input  logic         key_load,
   output logic         busy,
   output logic         key_ready,
   input  logic [3:0]   rd_idx,
   output logic [127:0] rd_key,
   output logic         rd_valid,
   output logic [127:0] last_key
);

   localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

   state_t state;
   state_t state_nxt;
   logic [3:0] cnt;
   block_t cur;
   block_t nxt;
   block_t store [NUM_ROUNDS+1];
   word_t t_comb;
   word_t t_use;
   logic load_ok;
   logic step_en;

`ifdef AES_KEYEXP_SBOX_PIPE_EN
   logic phase;
   word_t t_q;
   assign t_use   = t_q;
   assign step_en = (state == EXPAND) && phase;
`else
   assign t_use   = t_comb;
   assign step_en = (state == EXPAND);
`endif

   aes_key_step u_step (
      .cur  (cur),
      .rc   (rcon(cnt)),
      .t_out(t_comb),
      .t_in (t_use),
      .nxt  (nxt)
   );

   always_comb begin
      state_nxt = state;
      load_ok   = 1'b0;
      unique case (state)
         IDLE, DONE: begin
            load_ok = key_load;
            if (key_load) state_nxt = EXPAND;
         end
         EXPAND: begin
            if (step_en && cnt == LAST) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         cur       <= '0;
         busy      <= 1'b0;
         key_ready <= 1'b0;
         last_key  <= '0;
         for (int i = 0; i <= NUM_ROUNDS; i++) store[i] <= '0;
`ifdef AES_KEYEXP_SBOX_PIPE_EN
         phase     <= 1'b0;
         t_q       <= '0;
`endif
      end else begin
         state <= state_nxt;
         if (load_ok) begin
            store[0]  <= key_in;
            cur       <= key_in;
            cnt       <= 4'd1;
            key_ready <= 1'b0;
            busy      <= 1'b1;
`ifdef AES_KEYEXP_SBOX_PIPE_EN
            phase     <= 1'b0;
`endif
         end else if (step_en) begin
            store[cnt] <= nxt;
            cur        <= nxt;
            cnt        <= cnt + 4'd1;
`ifdef AES_KEYEXP_SBOX_PIPE_EN
            phase      <= 1'b0;
`endif
            if (cnt == LAST) begin
               last_key  <= nxt;
               busy      <= 1'b0;
               key_ready <= 1'b1;
            end
         end
`ifdef AES_KEYEXP_SBOX_PIPE_EN
         else if (state == EXPAND) begin
            t_q   <= t_comb;
            phase <= 1'b1;
         end
`endif
      end
   end

   // Entries past round 10 read as zero rather than aliasing.
   always_comb begin
      rd_key   = '0;
      rd_valid = 1'b0;
      if (rd_idx <= LAST) begin
         rd_key   = store[rd_idx];
         rd_valid = key_ready
                  | (busy & (rd_idx < cnt))
                  | (busy & (rd_idx == 4'd0));
      end
   end

endmodule

// File: tb/tb_aes128_key_expander.sv
// Self-checking bench for aes128_key_expander: FIPS-197 vectors, random keys
// against a word-array key schedule model, and busy/reset/reload sequences.
module tb_aes128_key_expander;

`ifdef AES_KEYEXP_SBOX_PIPE_EN
   localparam int STEP = 2;
`else
   localparam int STEP = 1;
`endif
   localparam int LAT = 10 * STEP;

   localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] key_in;
   logic         key_load;
   logic         busy;
   logic         key_ready;
   logic [3:0]   rd_idx;
   logic [127:0] rd_key;
   logic         rd_valid;
   logic [127:0] last_key;

   int n_pass = 0;
   int n_tot  = 0;

   logic [7:0]   sbt [256];
   logic [127:0] mdl [11];

   aes128_key_expander dut (
      .clk      (clk),
      .rst      (rst),
      .key_in   (key_in),
      .key_load (key_load),
      .busy     (busy),
      .key_ready(key_ready),
      .rd_idx   (rd_idx),
      .rd_key   (rd_key),
      .rd_valid (rd_valid),
      .last_key (last_key)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   // S-box from its definition: GF(2^8) inverse (x^254) then affine map.
   function automatic logic [7:0] sb_calc(input logic [7:0] x);
      logic [7:0] inv = 8'h01;
      logic [7:0] r;
      logic [7:0] s;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      s = inv ^ 8'h63;
      r = inv;
      for (int k = 0; k < 4; k++) begin
         r = {r[6:0], r[7]};
         s = s ^ r;
      end
      return s;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbt[w[31:24]], sbt[w[23:16]], sbt[w[15:8]], sbt[w[7:0]]};
   endfunction

   task automatic expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
            rc  = xt(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r < 11; r++)
         mdl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_tot++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endtask

   task automatic load(input logic [127:0] key);
      @(negedge clk);
      key_in   = key;
      key_load = 1'b1;
      @(negedge clk);
      key_load = 1'b0;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!key_ready && n < LAT + 10) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic check_all(input string nm);
      for (int i = 0; i < 11; i++) begin
         rd_idx = 4'(i);
         #1;
         chk($sformatf("%s_k%0d", nm, i), rd_key, mdl[i]);
         chk($sformatf("%s_v%0d", nm, i), 128'(rd_valid), 128'd1);
      end
      chk({nm, "_last"}, last_key, mdl[10]);
   endtask

   typedef struct {
      logic [127:0] key;
      logic [3:0]   idx;
      logic [127:0] exp;
      logic         vld;
   } vec_t;

   vec_t vt [7];

   initial begin
      int n;
      int m;
      logic [127:0] rk;
      logic [127:0] z7;

      for (int i = 0; i < 256; i++) sbt[i] = sb_calc(8'(i));

      vt[0] = '{FIPS,   4'd0,  FIPS, 1'b1};
      vt[1] = '{FIPS,   4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b1};
      vt[2] = '{FIPS,   4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1};
      vt[3] = '{128'h0, 4'd1,  128'h62636363626363636263636362636363, 1'b1};
      vt[4] = '{128'h0, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, 1'b1};
      vt[5] = '{128'h0, 4'd11, 128'h0, 1'b0};
      vt[6] = '{128'h0, 4'd0,  128'h0, 1'b1};

      rst = 1'b1;
      key_load = 1'b0;
      key_in = '0;
      rd_idx = 4'd0;
      repeat (2) @(negedge clk);
      chk("rst_busy",  128'(busy), 128'd0);
      chk("rst_ready", 128'(key_ready), 128'd0);
      chk("rst_last",  last_key, 128'd0);
      chk("rst_key0",  rd_key, 128'd0);
      chk("rst_vld0",  128'(rd_valid), 128'd0);
      rst = 1'b0;

      // Fixed vectors
      for (int i = 0; i < 7; i++) begin
         if (i == 0 || vt[i].key != vt[i-1].key) begin
            load(vt[i].key);
            wait_ready(n);
            chk($sformatf("vec%0d_lat", i), 128'(n), 128'(LAT));
         end
         rd_idx = vt[i].idx;
         #1;
         chk($sformatf("vec%0d_key", i), rd_key, vt[i].exp);
         chk($sformatf("vec%0d_vld", i), 128'(rd_valid), 128'(vt[i].vld));
         if (vt[i].idx == 4'd10)
            chk($sformatf("vec%0d_last", i), last_key, vt[i].exp);
      end

      // Random keys against the model
      for (int k = 0; k < 3; k++) begin
         rk = {$urandom(), $urandom(), $urandom(), $urandom()};
         expand(rk);
         load(rk);
         wait_ready(n);
         chk($sformatf("rnd%0d_lat", k), 128'(n), 128'(LAT));
         check_all($sformatf("rnd%0d", k));
      end

      // Second load while busy is ignored
      expand(FIPS);
      load(FIPS);
      repeat (3) @(negedge clk);
      key_in   = {$urandom(), $urandom(), $urandom(), $urandom()};
      key_load = 1'b1;
      @(negedge clk);
      key_load = 1'b0;
      wait_ready(m);
      chk("busyld_lat", 128'(m + 4), 128'(LAT));
      check_all("busyld");

      // Reset in the middle of an expansion
      load(FIPS);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rd_idx = 4'd3;
      #1;
      chk("midrst_busy",  128'(busy), 128'd0);
      chk("midrst_ready", 128'(key_ready), 128'd0);
      chk("midrst_last",  last_key, 128'd0);
      chk("midrst_k3",    rd_key, 128'd0);
      rst = 1'b0;
      rk = {$urandom(), $urandom(), $urandom(), $urandom()};
      expand(rk);
      load(rk);
      wait_ready(n);
      chk("postrst_lat", 128'(n), 128'(LAT));
      check_all("postrst");

      // Reload from DONE with the zero key
      expand(128'h0);
      z7 = mdl[7];
      load(128'h0);
      chk("reload_ready", 128'(key_ready), 128'd0);
      chk("reload_busy",  128'(busy), 128'd1);
      rd_idx = 4'd7;
      n = 0;
      forever begin
         #1;
         chk($sformatf("reload_v7_c%0d", n), 128'(rd_valid), 128'(n >= 7 * STEP));
         if (n >= 7 * STEP)
            chk($sformatf("reload_k7_c%0d", n), rd_key, z7);
         if (key_ready || n >= LAT + 5) break;
         @(negedge clk);
         n++;
      end
      chk("reload_lat", 128'(n), 128'(LAT));
      rd_idx = 4'd11;
      #1;
      chk("idx11_key", rd_key, 128'd0);
      chk("idx11_vld", 128'(rd_valid), 128'd0);
      check_all("reload");

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
